// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: shared widths, opcodes, command struct and FSM states for the plotter.
package vga_plot_pkg;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam logic [1:0] OP_PIXEL = 2'b00;
    localparam logic [1:0] OP_RECT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;
    typedef struct packed {
        logic [1:0]    op;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [CW-1:0] colour;
    } plot_cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_PIXEL, S_SCAN} state_t;
endpackage

// File: rtl/vga_plotter_if.sv
// vga_plotter_if: command handshake from the CPU side plus the plot stream to the VGA adapter.
interface vga_plotter_if;
    import vga_plot_pkg::*;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [XW-1:0] cmd_w;
    logic [YW-1:0] cmd_h;
    logic [CW-1:0] cmd_colour;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        input  cmd_ready, x, y, colour, plot, busy
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        output cmd_ready, x, y, colour, plot, busy
    );
endinterface

// File: rtl/plot_cmd_fifo.sv
// plot_cmd_fifo: command FIFO with wrap-bit read/write pointers.
module plot_cmd_fifo
    import vga_plot_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  logic      pop_i,
    input  plot_cmd_t din_i,
    output plot_cmd_t dout_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);
    plot_cmd_t mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic push, pop;
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/vga_plotter.sv
// vga_plotter: turns queued pixel/rect/clear commands into a one-pixel-per-cycle plot stream.
module vga_plotter
    import vga_plot_pkg::*;
#(
    parameter int unsigned XMAX       = 159,
    parameter int unsigned YMAX       = 119,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    vga_plotter_if.slave bus
);
    localparam logic [XW-1:0] XM  = XW'(XMAX);
    localparam logic [YW-1:0] YM  = YW'(YMAX);
    localparam logic [8:0]    XM9 = 9'(XMAX);
    localparam logic [8:0]    YM9 = 9'(YMAX);
    plot_cmd_t cmd_in, head;
    logic full, empty, pop;
    state_t state_q;
    logic [XW-1:0] x_q, xc_q, x0_q, xe_q, xe_d;
    logic [YW-1:0] y_q, yc_q, ye_q, ye_d;
    logic [CW-1:0] colour_q, col_q;
    logic plot_q, pix_ok_q;
    logic [8:0] xs9, ys9;
    logic in_range, rect_empty;

    assign cmd_in = '{op: bus.cmd_op, x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w,
                      h: bus.cmd_h, colour: bus.cmd_colour};
    assign pop    = (state_q == S_IDLE) && !empty;

    plot_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.cmd_valid && !full),
        .pop_i   (pop),
        .din_i   (cmd_in),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // 9-bit end coordinates so x+w-1 cannot wrap before clipping
    always_comb begin
        xs9        = {1'b0, head.x} + {1'b0, head.w} - 9'd1;
        ys9        = {2'b0, head.y} + {2'b0, head.h} - 9'd1;
        xe_d       = (xs9 > XM9) ? XM : xs9[XW-1:0];
        ye_d       = (ys9 > YM9) ? YM : ys9[YW-1:0];
        in_range   = (head.x <= XM) && (head.y <= YM);
        rect_empty = (head.w == '0) || (head.h == '0) || !in_range;
    end

    assign bus.cmd_ready = !full;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.plot      = plot_q;
    assign bus.busy      = !empty || (state_q != S_IDLE) || plot_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            xc_q     <= '0;
            yc_q     <= '0;
            x0_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            col_q    <= '0;
            pix_ok_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    if (!empty) begin
                        col_q <= head.colour;
                        case (head.op)
                            OP_PIXEL: begin
                                xc_q     <= head.x;
                                yc_q     <= head.y;
                                pix_ok_q <= in_range;
                                state_q  <= S_PIXEL;
                            end
                            OP_RECT: begin
                                xc_q <= head.x;
                                x0_q <= head.x;
                                yc_q <= head.y;
                                xe_q <= xe_d;
                                ye_q <= ye_d;
                                if (!rect_empty) state_q <= S_SCAN;
                            end
                            OP_CLEAR: begin
                                xc_q    <= '0;
                                x0_q    <= '0;
                                yc_q    <= '0;
                                xe_q    <= XM;
                                ye_q    <= YM;
                                state_q <= S_SCAN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_PIXEL: begin
                    plot_q  <= pix_ok_q;
                    state_q <= S_IDLE;
                    if (pix_ok_q) begin
                        x_q      <= xc_q;
                        y_q      <= yc_q;
                        colour_q <= col_q;
                    end
                end
                S_SCAN: begin
                    plot_q   <= 1'b1;
                    x_q      <= xc_q;
                    y_q      <= yc_q;
                    colour_q <= col_q;
                    if (xc_q == xe_q) begin
                        xc_q <= x0_q;
                        yc_q <= yc_q + YW'(1);
                        if (yc_q == ye_q) state_q <= S_IDLE;
                    end else begin
                        xc_q <= xc_q + XW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_plotter.sv
// tb_vga_plotter: randomized and directed checks of the plot stream against a pixel-list model.
module tb_vga_plotter;
    import vga_plot_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    typedef struct {int x; int y; int c; int t;} pix_t;
    pix_t obs_q[$];
    pix_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_plotter_if bus();
    vga_plotter #(.XMAX(159), .YMAX(119), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk)
        if (reset && bus.plot === 1'b1)
            obs_q.push_back('{int'(bus.x), int'(bus.y), int'(bus.colour), cyc});

    // Reference: every visible pixel a command paints, in raster order
    function automatic void model(input logic [1:0] op, input int x, y, w, h, c);
        if (op == OP_PIXEL) begin
            if (x <= 159 && y <= 119) exp_q.push_back('{x, y, c, 0});
        end else if (op == OP_RECT) begin
            for (int yy = y; yy < y + h && yy <= 119; yy++)
                for (int xx = x; xx < x + w && xx <= 159; xx++)
                    exp_q.push_back('{xx, yy, c, 0});
        end else if (op == OP_CLEAR) begin
            for (int yy = 0; yy <= 119; yy++)
                for (int xx = 0; xx <= 159; xx++)
                    exp_q.push_back('{xx, yy, c, 0});
        end
    endfunction

    function automatic int first_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c)
                return i;
        return (obs_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    task automatic send(input logic [1:0] op, input int x, y, w, h, c, output int t);
        int n = 0;
        logic acc = 1'b0;
        bus.cmd_op = op;
        bus.cmd_x = 8'(x);
        bus.cmd_y = 7'(y);
        bus.cmd_w = 8'(w);
        bus.cmd_h = 7'(h);
        bus.cmd_colour = 3'(c);
        bus.cmd_valid = 1'b1;
        while (!acc && n < 25000) begin
            acc = bus.cmd_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        t = cyc;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout op=%0d waited=%0d cycles required=accept", op, n);
        end
        model(op, x, y, w, h, c);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            quiet = (bus.busy === 1'b0 && bus.plot === 1'b0) ? quiet + 1 : 0;
            n++;
        end
        checks++;
        if (quiet < 3) begin
            failures++;
            $display("FAIL idle_timeout busy=%b after=%0d cycles required=0", bus.busy, n);
        end
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int t;
        clear_q();
        for (int i = 0; i < 5; i++)
            send(2'($urandom_range(0, 1)), $urandom_range(5, 150), $urandom_range(5, 110),
                 $urandom_range(4, 30), $urandom_range(2, 9), $urandom_range(1, 7), t);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks += 5;
        if (bus.plot !== 1'b0) begin failures++; $display("FAIL rst_plot got=%b exp=0", bus.plot); end
        if (bus.x !== 8'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", bus.x); end
        if (bus.y !== 7'd0) begin failures++; $display("FAIL rst_y got=%0d exp=0", bus.y); end
        if (bus.colour !== 3'd0) begin failures++; $display("FAIL rst_colour got=%0d exp=0", bus.colour); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        @(negedge clk) reset = 1'b1;
        clear_q();
        @(negedge clk);
        checks += 1;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.cmd_ready); end
        repeat (20) @(negedge clk);
        checks += 1;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rst_stale_plots got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_pixel();
        int t;
        clear_q();
        send(OP_PIXEL, 10, 20, 0, 0, 5, t);
        @(negedge clk);
        checks += 1;
        if (bus.plot !== 1'b0) begin failures++; $display("FAIL pix_early got=%b exp=0", bus.plot); end
        @(negedge clk);
        checks += 5;
        if (bus.plot !== 1'b1) begin failures++; $display("FAIL pix_plot got=%b exp=1", bus.plot); end
        if (bus.x !== 8'd10) begin failures++; $display("FAIL pix_x got=%0d exp=10", bus.x); end
        if (bus.y !== 7'd20) begin failures++; $display("FAIL pix_y got=%0d exp=20", bus.y); end
        if (bus.colour !== 3'd5) begin failures++; $display("FAIL pix_colour got=%0d exp=5", bus.colour); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL pix_busy_hi got=%b exp=1", bus.busy); end
        @(negedge clk);
        checks += 3;
        if (bus.plot !== 1'b0) begin failures++; $display("FAIL pix_one_shot got=%b exp=0", bus.plot); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL pix_busy_lo got=%b exp=0", bus.busy); end
        if (obs_q.size() != 1 || obs_q[0].t != t + 2) begin
            failures++;
            $display("FAIL pix_latency got_n=%0d exp_n=1 accept=%0d", obs_q.size(), t);
        end
    endtask

    task automatic test_rect();
        int t, d;
        logic gap = 1'b0;
        clear_q();
        send(OP_RECT, 3, 4, 3, 2, 2, t);
        wait_idle(200);
        d = first_diff();
        checks += 1;
        if (d != -1) begin failures++; $display("FAIL rect_stream idx=%0d got_n=%0d exp_n=%0d", d, obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].t != t + 2 + i) gap = 1'b1;
        checks += 1;
        if (gap || obs_q.size() != 6) begin failures++; $display("FAIL rect_timing got_n=%0d exp_n=6 gap=%b", obs_q.size(), gap); end
    endtask

    task automatic test_clip();
        int t, d;
        clear_q();
        send(OP_RECT, 158, 118, 5, 5, 6, t);
        send(OP_RECT, 10, 10, 0, 4, 1, t);
        send(OP_PIXEL, 200, 50, 0, 0, 3, t);
        send(OP_NOP, 1, 1, 1, 1, 1, t);
        wait_idle(200);
        d = first_diff();
        checks += 2;
        if (d != -1) begin failures++; $display("FAIL clip_stream idx=%0d got_n=%0d exp_n=%0d", d, obs_q.size(), exp_q.size()); end
        if (obs_q.size() != 4) begin failures++; $display("FAIL clip_count got=%0d exp=4", obs_q.size()); end
    endtask

    task automatic test_random();
        int t, d;
        clear_q();
        for (int i = 0; i < 16; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            if (op == OP_CLEAR) op = OP_NOP;
            send(op, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 12),
                 $urandom_range(0, 6), $urandom_range(0, 7), t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(2000);
        d = first_diff();
        checks += 1;
        if (d != -1) begin failures++; $display("FAIL random_stream idx=%0d got_n=%0d exp_n=%0d", d, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t, d;
        clear_q();
        send(OP_CLEAR, 0, 0, 0, 0, 3, t);
        for (int i = 0; i < 6; i++) begin
            send(OP_PIXEL, i * 7, i * 3, 0, 0, (i + 1) % 8, t);
            if (i == 3) begin
                checks += 1;
                if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.cmd_ready); end
            end
        end
        wait_idle(25000);
        d = first_diff();
        checks += 2;
        if (d != -1) begin failures++; $display("FAIL b2b_stream idx=%0d got_n=%0d exp_n=%0d", d, obs_q.size(), exp_q.size()); end
        if (obs_q.size() < 19200 || obs_q[19199].t - obs_q[0].t != 19199) begin
            failures++;
            $display("FAIL clear_contiguous got_n=%0d exp_span=19199", obs_q.size());
        end
    endtask

    task automatic test_abort();
        int t, d;
        int n = 0;
        clear_q();
        send(OP_CLEAR, 0, 0, 0, 0, 7, t);
        while (obs_q.size() < 1000 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks += 1;
        if (obs_q.size() < 1000) begin failures++; $display("FAIL abort_reach got=%0d exp=1000", obs_q.size()); end
        #1 reset = 1'b0;
        #1;
        checks += 2;
        if (bus.plot !== 1'b0) begin failures++; $display("FAIL abort_plot got=%b exp=0", bus.plot); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        @(negedge clk) reset = 1'b1;
        clear_q();
        repeat (3) @(negedge clk);
        send(OP_PIXEL, 0, 0, 0, 0, 4, t);
        wait_idle(200);
        d = first_diff();
        checks += 1;
        if (d != -1 || obs_q.size() != 1) begin
            failures++;
            $display("FAIL abort_after idx=%0d got_n=%0d exp_n=1", d, obs_q.size());
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_NOP;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_colour = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_pixel();
        test_rect();
        test_clip();
        test_random();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
